// File: rtl/dbg_pkg.sv
// Shared types for the PC watch / register dump block.
package dbg_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_BP   = 2'd1;
  localparam logic [1:0] CAUSE_TMO  = 2'd2;
endpackage

// File: rtl/pc_watch_dumper_bp_match.sv
// Combinational breakpoint compare across all channels; lowest matching channel wins.
module bp_match #(
  parameter int NUM_BP = 4,
  parameter int ADDR_W = 32,
  parameter int HW     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic [ADDR_W-1:0]        pc_i,
  input  logic                     pc_valid_i,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr_i,
  input  logic [NUM_BP-1:0]        bp_en_i,
  output logic                     hit_o,
  output logic [HW-1:0]            hit_id_o
);
  logic [NUM_BP-1:0] match;

  for (genvar k = 0; k < NUM_BP; k++) begin : g_ch
    assign match[k] = pc_valid_i && bp_en_i[k] && (pc_i == bp_addr_i[k*ADDR_W +: ADDR_W]);
  end

  // Scan high to low so the lowest matching channel is the last to write.
  always_comb begin
    hit_o    = 1'b0;
    hit_id_o = '0;
    for (int k = NUM_BP - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit_o    = 1'b1;
        hit_id_o = HW'(k);
      end
    end
  end
endmodule

// File: rtl/pc_watch_dumper.sv
// Halts the core on a breakpoint or cycle timeout, then streams every
// architectural register out over a valid/ready port.
module pc_watch_dumper
  import dbg_pkg::*;
#(
  parameter int NUM_BP = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CYC_W  = 16,
  parameter int IDX_W  = $clog2(NREG),
  parameter int HW     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     arm_i,
  input  logic [ADDR_W-1:0]        pc_i,
  input  logic                     pc_valid_i,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr_i,
  input  logic [NUM_BP-1:0]        bp_en_i,
  input  logic [CYC_W-1:0]         cyc_limit_i,
  output logic                     halt_o,
  output logic [IDX_W-1:0]         reg_sel_o,
  input  logic [DATA_W-1:0]        reg_data_i,
  output logic                     dump_valid_o,
  input  logic                     dump_ready_i,
  output logic [IDX_W-1:0]         dump_idx_o,
  output logic [DATA_W-1:0]        dump_data_o,
  output logic                     done_o,
  output logic [1:0]               cause_o,
  output logic [HW-1:0]            hit_id_o,
  output logic [CYC_W-1:0]         cycle_cnt_o
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG - 1);

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        cause_q, cause_d;
  logic [HW-1:0]     hit_id_q, hit_id_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic          bp_hit;
  logic [HW-1:0] bp_id;
  logic          tmo;

  bp_match #(.NUM_BP(NUM_BP), .ADDR_W(ADDR_W), .HW(HW)) u_bp_match (
    .pc_i       (pc_i),
    .pc_valid_i (pc_valid_i),
    .bp_addr_i  (bp_addr_i),
    .bp_en_i    (bp_en_i),
    .hit_o      (bp_hit),
    .hit_id_o   (bp_id)
  );

  // A saturated counter (all ones) can never equal limit-1, so no extra guard is needed.
  assign tmo = (cyc_limit_i != '0) && (cnt_q == cyc_limit_i - 1'b1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    hit_id_d = hit_id_q;
    idx_d    = idx_q;
    data_d   = data_q;
    case (state_q)
      IDLE, DONE: begin
        if (arm_i) begin
          state_d  = RUN;
          cnt_d    = '0;
          cause_d  = CAUSE_NONE;
          hit_id_d = '0;
        end
      end
      RUN: begin
        if (bp_hit || tmo) begin
          // Counter freezes at the value seen in the hit cycle; beat 0 loads now.
          state_d  = DUMP;
          cause_d  = bp_hit ? CAUSE_BP : CAUSE_TMO;
          hit_id_d = bp_hit ? bp_id : '0;
          idx_d    = '0;
          data_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DUMP: begin
        if (dump_ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = reg_data_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cause_q  <= CAUSE_NONE;
      hit_id_q <= '0;
      idx_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      hit_id_q <= hit_id_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
    end
  end

  assign halt_o       = (state_q == DUMP) || (state_q == DONE);
  assign done_o       = (state_q == DONE);
  assign dump_valid_o = (state_q == DUMP);
  assign reg_sel_o    = (state_q == DUMP) ? idx_q + 1'b1 : '0;
  assign dump_idx_o   = idx_q;
  assign dump_data_o  = data_q;
  assign cause_o      = cause_q;
  assign hit_id_o     = hit_id_q;
  assign cycle_cnt_o  = cnt_q;
endmodule

// File: tb/tb_pc_watch_dumper.sv
// Directed bench: stimulus pushes expected dump beats, a negedge monitor checks them.
module tb_pc_watch_dumper;
  logic         clk = 1'b0;
  logic         rstn;
  logic         arm_i;
  logic [31:0]  pc_i;
  logic         pc_valid_i;
  logic [127:0] bp_addr_i;
  logic [3:0]   bp_en_i;
  logic [15:0]  cyc_limit_i;
  logic         halt_o;
  logic [4:0]   reg_sel_o;
  logic [31:0]  reg_data_i;
  logic         dump_valid_o;
  logic         dump_ready_i = 1'b1;
  logic [4:0]   dump_idx_o;
  logic [31:0]  dump_data_o;
  logic         done_o;
  logic [1:0]   cause_o;
  logic [1:0]   hit_id_o;
  logic [15:0]  cycle_cnt_o;

  typedef struct {logic [4:0] idx; logic [31:0] data;} beat_t;
  beat_t exp_q[$];

  logic [31:0] rf [32];
  int n_chk = 0;
  int n_fail = 0;
  bit rdy_rand = 1'b1;

  always #5 clk = ~clk;
  assign reg_data_i = rf[reg_sel_o];

  pc_watch_dumper dut (
    .clk(clk), .rstn(rstn), .arm_i(arm_i), .pc_i(pc_i), .pc_valid_i(pc_valid_i),
    .bp_addr_i(bp_addr_i), .bp_en_i(bp_en_i), .cyc_limit_i(cyc_limit_i),
    .halt_o(halt_o), .reg_sel_o(reg_sel_o), .reg_data_i(reg_data_i),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_idx_o(dump_idx_o), .dump_data_o(dump_data_o), .done_o(done_o),
    .cause_o(cause_o), .hit_id_o(hit_id_o), .cycle_cnt_o(cycle_cnt_o)
  );

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_beats(int n);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.idx  = 5'(i);
      b.data = (i == 0) ? 32'h0 : rf[i];
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_done(string nm);
    for (int k = 0; k < 400 && !done_o; k++) tick();
    check(nm, done_o, 1);
    check({nm, "_halt"}, halt_o, 1);
    check({nm, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_zero(string nm);
    check({nm, "_halt"}, halt_o, 0);
    check({nm, "_valid"}, dump_valid_o, 0);
    check({nm, "_done"}, done_o, 0);
    check({nm, "_cause"}, cause_o, 0);
    check({nm, "_hitid"}, hit_id_o, 0);
    check({nm, "_cnt"}, cycle_cnt_o, 0);
    check({nm, "_sel"}, reg_sel_o, 0);
    check({nm, "_idx"}, dump_idx_o, 0);
    check({nm, "_data"}, dump_data_o, 0);
  endtask

  // Ready driver: random backpressure or always ready.
  initial forever begin
    @(posedge clk);
    #1;
    dump_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: compares accepted beats against the queue and checks stall stability.
  initial begin
    bit stall = 1'b0;
    logic [4:0]  s_idx;
    logic [31:0] s_data;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall = 1'b0;
      end else begin
        if (stall && dump_valid_o) begin
          check("hold_idx", dump_idx_o, s_idx);
          check("hold_data", dump_data_o, s_data);
        end
        if (dump_valid_o && dump_ready_i) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL extra_beat: got idx %0d data %0h with nothing expected", dump_idx_o, dump_data_o);
          end else begin
            beat_t b;
            b = exp_q.pop_front();
            check("beat_idx", dump_idx_o, b.idx);
            check("beat_data", dump_data_o, b.data);
          end
        end
        stall  = dump_valid_o && !dump_ready_i;
        s_idx  = dump_idx_o;
        s_data = dump_data_o;
      end
    end
  end

  initial begin
    bit found;
    for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 | (i * 32'h111);
    rf[7] = 32'hDEADBEEF;
    rf[0] = 32'h5;
    rstn = 1'b0; arm_i = 1'b0; pc_i = '0; pc_valid_i = 1'b0;
    bp_addr_i = '0; bp_en_i = '0; cyc_limit_i = '0;
    tick(3);
    check_zero("rst");
    rstn = 1'b1;
    tick();

    // Walk PC up to breakpoint 0, random backpressure during the dump.
    bp_addr_i[0 +: 32] = 32'h310;
    bp_en_i = 4'b0001;
    push_beats(32);
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    check("t1_cnt0", cycle_cnt_o, 0);
    for (int p = 'h300; p <= 'h310; p += 4) begin
      pc_i = 32'(p); pc_valid_i = 1'b1;
      tick();
      check("t1_halt", halt_o, (p == 'h310));
    end
    pc_valid_i = 1'b0;
    check("t1_cause", cause_o, 1);
    check("t1_hitid", hit_id_o, 0);
    check("t1_cnt", cycle_cnt_o, 4);
    check("t1_valid", dump_valid_o, 1);
    check("t1_idx0", dump_idx_o, 0);
    wait_done("t1_done");
    check("t1_valid_drop", dump_valid_o, 0);

    // Re-arm from DONE releases halt on the next edge.
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    check("rearm_halt", halt_o, 0);
    check("rearm_done", done_o, 0);
    check("rearm_cnt", cycle_cnt_o, 0);
    check("rearm_cause", cause_o, 0);

    // Two channels on the same address: lowest wins.
    bp_addr_i[32 +: 32] = 32'h40;
    bp_addr_i[96 +: 32] = 32'h40;
    bp_en_i = 4'b1010;
    push_beats(32);
    pc_i = 32'h40; pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    check("t2_halt", halt_o, 1);
    check("t2_cause", cause_o, 1);
    check("t2_hitid", hit_id_o, 1);
    wait_done("t2_done");

    // Timeout at 1000 RUN cycles.
    bp_en_i = '0; cyc_limit_i = 16'd1000;
    push_beats(32);
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    tick(999);
    check("t3_nohalt", halt_o, 0);
    check("t3_cnt_pre", cycle_cnt_o, 999);
    tick();
    check("t3_halt", halt_o, 1);
    check("t3_cause", cause_o, 2);
    check("t3_cnt", cycle_cnt_o, 999);
    wait_done("t3_done");

    // No limit: counter saturates and a limit applied afterwards never fires.
    cyc_limit_i = '0;
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    tick(70000);
    check("t3_sat_halt", halt_o, 0);
    check("t3_sat_cnt", cycle_cnt_o, 16'hFFFF);
    cyc_limit_i = 16'hFFFF;
    tick(4);
    check("t3_sat_nomatch", halt_o, 0);
    check("t3_sat_hold", cycle_cnt_o, 16'hFFFF);

    rstn = 1'b0; tick(); rstn = 1'b1; tick();

    // Timeout and breakpoint in the same cycle.
    cyc_limit_i = 16'd3;
    bp_addr_i[0 +: 32] = 32'h500;
    bp_en_i = 4'b0001;
    push_beats(32);
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    tick(2);
    pc_i = 32'h500; pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    check("t6_halt", halt_o, 1);
    check("t6_cause", cause_o, 1);
    check("t6_hitid", hit_id_o, 0);
    check("t6_cnt", cycle_cnt_o, 2);
    wait_done("t6_done");
    cyc_limit_i = '0; bp_en_i = '0;
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    check("t6_release", halt_o, 0);

    // Async reset in the middle of beat 12.
    rdy_rand = 1'b0;
    bp_addr_i[0 +: 32] = 32'h600;
    bp_en_i = 4'b0001;
    push_beats(12);
    pc_i = 32'h600; pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (dump_valid_o && dump_idx_o == 5'd12) found = 1'b1;
      else tick();
    end
    check("t5_reach12", found, 1);
    rstn = 1'b0;
    #1;
    check_zero("t5_async");
    check("t5_drained", exp_q.size(), 0);
    tick();
    rstn = 1'b1;
    tick();
    check_zero("t5_idle");

    // Clean re-arm after reset.
    rdy_rand = 1'b1;
    push_beats(32);
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    pc_i = 32'h600; pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    check("t5_rearm_halt", halt_o, 1);
    check("t5_rearm_cause", cause_o, 1);
    wait_done("t5_rearm_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
